// File: rtl/mult_pipe_stage_if.sv
// Handshake bundle for mult_pipe_stage: upstream valid/ready/data/tag and downstream valid/ready/data/tag.
// The stage itself uses the slave view; the producer/consumer side uses the master view.
interface mult_pipe_stage_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int TAG_W    = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [TAG_W-1:0]          in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic [TAG_W-1:0]          out_tag;

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/mult_pipe_stage.sv
// Pipeline register stage between partial-product stages: CHANNELS lanes plus tag, two-entry skid buffer.
// Optional macro MULT_PIPE_STALL_CNT_EN adds a saturating 16-bit stall_count output.
`default_nettype none

module mult_pipe_stage #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int TAG_W    = 5
) (
   input  wire logic        clock,
   input  wire logic        reset,
   input  wire logic        flush,
   mult_pipe_stage_if.slave io
`ifdef MULT_PIPE_STALL_CNT_EN
   ,
   output logic [15:0]      stall_count
`endif
);
   localparam int DW = CHANNELS * WIDTH;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   logic             vld_p1;
   logic [DW-1:0]    data_p1;
   logic [TAG_W-1:0] tag_p1;

   logic             skid_vld;
   logic [DW-1:0]    skid_data;
   logic [TAG_W-1:0] skid_tag;

   logic xfer_in;
   logic main_open;

   // in_ready comes straight from the skid flop, so there is no path from out_ready.
   assign xfer_in   = io.in_valid & ~skid_vld;
   assign main_open = ~vld_p1 | io.out_ready;

   // ---- stage p1: main entry drives the outputs, skid only fills while stalled
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         skid_vld <= 1'b0;
         data_p1  <= '0;
         tag_p1   <= '0;
      end else if (flush) begin
         vld_p1   <= 1'b0;
         skid_vld <= 1'b0;
      end else if (main_open) begin
         vld_p1 <= skid_vld | xfer_in;
         if (skid_vld) begin
            data_p1  <= skid_data;
            tag_p1   <= skid_tag;
            skid_vld <= 1'b0;
         end else if (xfer_in) begin
            data_p1 <= io.in_data;
            tag_p1  <= io.in_tag;
         end
      end else if (xfer_in) begin
         skid_vld  <= 1'b1;
         skid_data <= io.in_data;
         skid_tag  <= io.in_tag;
      end
   end

   assign io.in_ready  = ~skid_vld;
   assign io.out_valid = vld_p1;
   assign io.out_data  = data_p1;
   assign io.out_tag   = tag_p1;

`ifdef MULT_PIPE_STALL_CNT_EN
   // Flush deliberately leaves the count alone; only reset clears it.
   always_ff @(posedge clock) begin
      if (reset)
         stall_count <= '0;
      else if (vld_p1 & ~io.out_ready)
         stall_count <= sat_inc16(stall_count);
   end
`endif

endmodule

`default_nettype wire
